// File: rtl/bird_motion_ctrl.sv
// -----------------------------------------------------------------------------
// bird_motion_ctrl
//   Bird kinematics and collision engine for FlappyBird. Owns the bird's
//   vertical position, signed velocity, flap handling and death detection.
//   Physics advances only on cycles where the clk_ms strobe is high.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   clk_ms      single-cycle physics tick, synchronous to clk
//   up_button   debounced flap button (level)
//   state       game state: 00 menu, 01 play, 10 pause, 11 over
//   pipe_x      per-channel pipe left edge, channel i at [i*X_W +: X_W]
//   gap_top     per-channel top of gap,    channel i at [i*Y_W +: Y_W]
//   gap_bot     per-channel bottom of gap, channel i at [i*Y_W +: Y_W]
//   pipe_valid  per-channel "pipe is on screen"
//   bird_y      bird top edge (y grows downward)
//   bird_vel    signed velocity, negative is up
//   isDead      bird has hit a pipe or the ground
//   bird_st     00 IDLE, 01 FLY, 10 FALL, 11 DEAD
//
// Build option
//   CEILING_KILL_EN  when defined, leaving the top of the screen while flying
//                    kills the bird (FALL, isDead=1) instead of clamping it.
// -----------------------------------------------------------------------------
module bird_motion_ctrl #(
   parameter int Y_W       = 10,
   parameter int X_W       = 10,
   parameter int V_W       = 6,
   parameter int NUM_PIPES = 2,
   parameter int SCREEN_H  = 480,
   parameter int BIRD_X    = 160,
   parameter int BIRD_W    = 34,
   parameter int BIRD_H    = 24,
   parameter int PIPE_W    = 52,
   parameter int Y_START   = 228,
   parameter int GRAVITY   = 1,
   parameter int FLAP_VEL  = 8,
   parameter int VEL_MAX   = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_ms,
   input  logic                     up_button,
   input  logic [1:0]               state,
   input  logic [NUM_PIPES*X_W-1:0] pipe_x,
   input  logic [NUM_PIPES*Y_W-1:0] gap_top,
   input  logic [NUM_PIPES*Y_W-1:0] gap_bot,
   input  logic [NUM_PIPES-1:0]     pipe_valid,
   output logic [Y_W-1:0]           bird_y,
   output logic [V_W-1:0]           bird_vel,
   output logic                     isDead,
   output logic [1:0]               bird_st
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FLY  = 2'b01,
      ST_FALL = 2'b10,
      ST_DEAD = 2'b11
   } bird_st_e;

   localparam logic [1:0] GS_MENU = 2'b00;
   localparam logic [1:0] GS_PLAY = 2'b01;

   // Vertical maths carries a sign bit plus one guard bit so that y+vel and
   // y+BIRD_H can neither wrap nor be mistaken for a negative position.
   localparam int YS_W = Y_W + 2;

   localparam logic signed [V_W:0]    GRAV_X     = (V_W+1)'(GRAVITY);
   localparam logic signed [V_W:0]    VEL_MAX_X  = (V_W+1)'(VEL_MAX);
   localparam logic signed [V_W-1:0]  FLAP_NEG   = V_W'(-FLAP_VEL);
   localparam logic signed [YS_W-1:0] BIRD_H_S   = YS_W'(BIRD_H);
   localparam logic signed [YS_W-1:0] SCREEN_H_S = YS_W'(SCREEN_H);
   localparam logic [Y_W-1:0]         Y_GROUND   = Y_W'(SCREEN_H - BIRD_H);
   localparam logic [X_W:0]           BIRD_R_X   = (X_W+1)'(BIRD_X + BIRD_W);
   localparam logic [X_W:0]           BIRD_L_X   = (X_W+1)'(BIRD_X);
   localparam logic [X_W:0]           PIPE_W_X   = (X_W+1)'(PIPE_W);

   bird_st_e              st_q, st_d;
   logic [Y_W-1:0]        y_q, y_d;
   logic signed [V_W-1:0] vel_q, vel_d;
   logic                  dead_q, dead_d;
   logic                  pend_q, pend_d;
   logic                  up_q, up_d;

   logic                  flap_edge, flap_eff;
   logic signed [V_W:0]   vel_grav;
   logic signed [V_W-1:0] vel_fall, vel_step;
   logic signed [YS_W-1:0] y_n, y_bot;
   logic                  ground, ceil, hit;

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         y_q    <= Y_W'(Y_START);
         vel_q  <= '0;
         dead_q <= 1'b0;
         pend_q <= 1'b0;
         up_q   <= 1'b0;
      end else begin
         st_q   <= st_d;
         y_q    <= y_d;
         vel_q  <= vel_d;
         dead_q <= dead_d;
         pend_q <= pend_d;
         up_q   <= up_d;
      end
   end

   // ------------------------------------------------------ physics candidates
   // NOTE: every variable of a combinational block gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      flap_edge = up_button & ~up_q;
      // A fresh edge on the tick cycle counts as a flap on that tick.
      flap_eff  = pend_q | flap_edge;

      vel_grav  = (V_W+1)'(vel_q) + GRAV_X;
      vel_fall  = (vel_grav > VEL_MAX_X) ? V_W'(VEL_MAX_X) : V_W'(vel_grav);
      vel_step  = (st_q == ST_FLY && flap_eff) ? FLAP_NEG : vel_fall;

      y_n       = $signed({2'b00, y_q}) + YS_W'(vel_step);
      y_bot     = y_n + BIRD_H_S;
      ground    = (y_bot >= SCREEN_H_S);
      ceil      = y_n[YS_W-1];

      hit = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (pipe_valid[i]
             && ({1'b0, pipe_x[i*X_W +: X_W]} < BIRD_R_X)
             && (({1'b0, pipe_x[i*X_W +: X_W]} + PIPE_W_X) > BIRD_L_X)
             && ((y_n < $signed({2'b00, gap_top[i*Y_W +: Y_W]}))
                 || (y_bot > $signed({2'b00, gap_bot[i*Y_W +: Y_W]}))))
            hit = 1'b1;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      st_d   = st_q;
      y_d    = y_q;
      vel_d  = vel_q;
      dead_d = dead_q;
      pend_d = pend_q;
      // The edge detector keeps tracking the button in every game state so a
      // held button never produces a phantom edge on return to play.
      up_d   = up_button;

      if (state == GS_MENU) begin
         st_d   = ST_IDLE;
         y_d    = Y_W'(Y_START);
         vel_d  = '0;
         dead_d = 1'b0;
         pend_d = 1'b0;
      end else if (state == GS_PLAY) begin
         unique case (st_q)
            ST_IDLE: begin
               if (flap_eff) begin
                  st_d   = ST_FLY;
                  pend_d = 1'b1;   // kept so the first tick applies the flap
               end
            end
            ST_FLY: begin
               if (!clk_ms) begin
                  pend_d = flap_eff;
               end else begin
                  pend_d = 1'b0;
                  if (ground) begin
                     y_d    = Y_GROUND;
                     vel_d  = '0;
                     st_d   = ST_DEAD;
                     dead_d = 1'b1;
                  end else if (ceil) begin
                     y_d   = '0;
                     vel_d = '0;
`ifdef CEILING_KILL_EN
                     st_d   = ST_FALL;
                     dead_d = 1'b1;
`else
                     if (hit) begin
                        st_d   = ST_FALL;
                        dead_d = 1'b1;
                     end
`endif
                  end else if (hit) begin
                     y_d    = y_n[Y_W-1:0];
                     vel_d  = '0;
                     st_d   = ST_FALL;
                     dead_d = 1'b1;
                  end else begin
                     y_d   = y_n[Y_W-1:0];
                     vel_d = vel_step;
                  end
               end
            end
            ST_FALL: begin
               pend_d = 1'b0;
               if (clk_ms) begin
                  if (ground) begin
                     y_d   = Y_GROUND;
                     vel_d = '0;
                     st_d  = ST_DEAD;
                  end else begin
                     y_d   = y_n[Y_W-1:0];
                     vel_d = vel_step;
                  end
               end
            end
            default: begin
               pend_d = 1'b0;
            end
         endcase
      end
      // Pause / over: everything holds and edges are not latched.
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      bird_y   = y_q;
      bird_vel = vel_q;
      isDead   = dead_q;
      bird_st  = st_q;
   end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
module tb_bird_motion_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_ms;
   logic        up_button;
   logic [1:0]  state;
   logic [19:0] pipe_x;
   logic [19:0] gap_top;
   logic [19:0] gap_bot;
   logic [1:0]  pipe_valid;
   logic [9:0]  bird_y;
   logic [5:0]  bird_vel;
   logic        isDead;
   logic [1:0]  bird_st;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   bird_motion_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .clk_ms    (clk_ms),
      .up_button (up_button),
      .state     (state),
      .pipe_x    (pipe_x),
      .gap_top   (gap_top),
      .gap_bot   (gap_bot),
      .pipe_valid(pipe_valid),
      .bird_y    (bird_y),
      .bird_vel  (bird_vel),
      .isDead    (isDead),
      .bird_st   (bird_st)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   // Bird physics in plain integers: positions and velocities are ordinary
   // numbers, game rules applied directly (0 idle, 1 fly, 2 fall, 3 dead).
   int m_y = 228, m_v = 0, m_st = 0, m_dead = 0, m_pend = 0, m_prev = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit pipe_hit(input int ny);
      for (int i = 0; i < 2; i++) begin
         int x, top, bot;
         x   = int'(pipe_x[i*10 +: 10]);
         top = int'(gap_top[i*10 +: 10]);
         bot = int'(gap_bot[i*10 +: 10]);
         if (pipe_valid[i] && x < 160 + 34 && x + 52 > 160 &&
             (ny < top || ny + 24 > bot))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk) begin : model
      bit edge_b, flap, hit;
      int nv, ny;
      edge_b = up_button && (m_prev == 0);
      if (rst) begin
         m_y = 228; m_v = 0; m_st = 0; m_dead = 0; m_pend = 0; m_prev = 0;
      end else begin
         if (state == 2'b00) begin
            m_y = 228; m_v = 0; m_st = 0; m_dead = 0; m_pend = 0;
         end else if (state == 2'b01) begin
            flap = (m_pend != 0) || edge_b;
            if (m_st == 0) begin
               if (flap) begin m_st = 1; m_pend = 1; end
            end else if (m_st == 1) begin
               if (!clk_ms) m_pend = flap;
               else begin
                  m_pend = 0;
                  nv  = flap ? -8 : imin(m_v + 1, 10);
                  ny  = m_y + nv;
                  hit = pipe_hit(ny);
                  if (ny + 24 >= 480) begin
                     m_y = 456; m_v = 0; m_st = 3; m_dead = 1;
                  end else if (ny < 0) begin
                     m_y = 0; m_v = 0;
`ifdef CEILING_KILL_EN
                     m_st = 2; m_dead = 1;
`else
                     if (hit) begin m_st = 2; m_dead = 1; end
`endif
                  end else if (hit) begin
                     m_y = ny; m_v = 0; m_st = 2; m_dead = 1;
                  end else begin
                     m_y = ny; m_v = nv;
                  end
               end
            end else if (m_st == 2) begin
               m_pend = 0;
               if (clk_ms) begin
                  nv = imin(m_v + 1, 10);
                  ny = m_y + nv;
                  if (ny + 24 >= 480) begin m_y = 456; m_v = 0; m_st = 3; end
                  else begin m_y = ny; m_v = nv; end
               end
            end else begin
               m_pend = 0;
            end
         end
         m_prev = up_button ? 1 : 0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_y",    bird_y,              m_y);
         check("model_vel",  $signed(bird_vel),   m_v);
         check("model_st",   bird_st,             m_st);
         check("model_dead", isDead,              m_dead);
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic tick();
      @(negedge clk) clk_ms = 1'b1;
      @(negedge clk) clk_ms = 1'b0;
   endtask

   task automatic press();
      @(negedge clk) up_button = 1'b1;
      @(negedge clk) up_button = 1'b0;
   endtask

   // Button edge on the same cycle as the tick.
   task automatic flap_tick();
      @(negedge clk) begin up_button = 1'b1; clk_ms = 1'b1; end
      @(negedge clk) begin up_button = 1'b0; clk_ms = 1'b0; end
   endtask

   task automatic expect_out(input string tag, input int y, input int v,
                             input int st, input int dead);
      check({tag, "_y"},    bird_y,            y);
      check({tag, "_vel"},  $signed(bird_vel), v);
      check({tag, "_st"},   bird_st,           st);
      check({tag, "_dead"}, isDead,            dead);
   endtask

   task automatic run_to_dead();
      for (int i = 0; i < 100 && bird_st != 2'b11; i++) tick();
   endtask

   initial begin
      rst = 1'b1; clk_ms = 1'b0; up_button = 1'b0; state = 2'b00;
      pipe_x = '0; gap_top = '0; gap_bot = '0; pipe_valid = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      expect_out("reset", 228, 0, 0, 0);

      // Play without a flap: bird stays parked.
      state = 2'b01;
      repeat (20) tick();
      expect_out("idle20", 228, 0, 0, 0);

      // Flap then three ticks.
      press();
      tick(); expect_out("flap1", 220, -8, 1, 0);
      tick(); expect_out("flap2", 213, -7, 1, 0);
      tick(); expect_out("flap3", 207, -6, 1, 0);

      // Pause with button toggling: frozen, nothing latched.
      @(negedge clk) state = 2'b10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) begin up_button = ~up_button; clk_ms = 1'b1; end
         @(negedge clk) clk_ms = 1'b0;
      end
      expect_out("pause", 207, -6, 1, 0);
      @(negedge clk) state = 2'b01;
      tick(); expect_out("resume", 202, -5, 1, 0);

      // Pipes at the horizontal boundaries: x=108 ends exactly at BIRD_X,
      // x=194 starts exactly at the bird's right edge -> no hit.
      pipe_x     = {10'd194, 10'd108};
      gap_top    = {10'd100, 10'd0};
      gap_bot    = {10'd200, 10'd10};
      pipe_valid = 2'b11;
      tick(); expect_out("pipe_edge", 198, -4, 1, 0);
      // Channel 1 overlaps; bird bottom 219 below gap bottom 200.
      pipe_x[19:10] = 10'd150;
      tick(); expect_out("pipe_hit", 195, 0, 2, 1);
      press(); tick();
      press(); tick();
      expect_out("fall2", 198, 2, 2, 1);
      repeat (8) tick();
      expect_out("fall_sat", 250, 10, 2, 1);
      run_to_dead();
      expect_out("fall_ground", 456, 0, 3, 1);
      repeat (3) tick();
      expect_out("dead_frozen", 456, 0, 3, 1);

      // Back to menu.
      @(negedge clk) state = 2'b00;
      @(negedge clk) expect_out("menu", 228, 0, 0, 0);
      pipe_valid = 2'b00;
      state = 2'b01;

      // Single flap then free flight to the ground.
      press();
      repeat (19) tick();
      expect_out("fly_sat", 247, 10, 1, 0);
      run_to_dead();
      expect_out("fly_ground", 456, 0, 3, 1);

      // Ceiling: flap on every tick from 228.
      @(negedge clk) state = 2'b00;
      @(negedge clk) state = 2'b01;
      press();
      repeat (28) flap_tick();
      expect_out("ceil_pre", 4, -8, 1, 0);
      flap_tick();
`ifdef CEILING_KILL_EN
      expect_out("ceil_kill", 0, 0, 2, 1);
`else
      expect_out("ceil_clamp", 0, 0, 1, 0);
      repeat (3) flap_tick();
      expect_out("ceil_hold", 0, 0, 1, 0);
      tick();
      expect_out("ceil_drop", 1, 1, 1, 0);
`endif

      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
